// File: rtl/mqfu_axil_regs.sv
// AXI4-Lite register front-end for the quaternion filter core: operand regs, start/done handshake, result capture.
// Optional level interrupt output enabled by defining MQFU_AXIL_REGS_IRQ_EN.
module mqfu_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
`ifdef MQFU_AXIL_REGS_IRQ_EN
    output logic                              irq,
`endif
    output logic                              core_start,
    output logic signed [15:0]                core_ax,
    output logic signed [15:0]                core_ay,
    output logic signed [15:0]                core_az,
    output logic signed [15:0]                core_gx,
    output logic signed [15:0]                core_gy,
    output logic signed [15:0]                core_gz,
    input  logic                              core_done,
    input  logic [31:0]                       core_q0,
    input  logic [31:0]                       core_q1,
    input  logic [31:0]                       core_q2,
    input  logic [31:0]                       core_q3
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTRL   = AW'(8'h00);
    localparam logic [AW-1:0] A_STATUS = AW'(8'h04);
    localparam logic [AW-1:0] A_ACC_XY = AW'(8'h08);
    localparam logic [AW-1:0] A_ACC_Z  = AW'(8'h0C);
    localparam logic [AW-1:0] A_GYR_XY = AW'(8'h10);
    localparam logic [AW-1:0] A_GYR_Z  = AW'(8'h14);
    localparam logic [AW-1:0] A_Q0     = AW'(8'h18);
    localparam logic [AW-1:0] A_Q1     = AW'(8'h1C);
    localparam logic [AW-1:0] A_Q2     = AW'(8'h20);
    localparam logic [AW-1:0] A_Q3     = AW'(8'h24);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic start_d;

    logic [31:0] acc_xy, gyr_xy, q0, q1, q2, q3, rd_mux;
    logic [15:0] acc_z, gyr_z;
    logic        done, irq_en_bit;
    logic        wr_hs, rd_hs, busy, done_evt, start_req, wr_data_reg, wr_reject;
    logic [AW-1:0] waddr, raddr;
    logic        unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? din[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    // Ready is combinational so the accepted beat and the register update share one cycle.
    assign wr_hs = s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_areset;
    assign rd_hs = s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_areset;
    assign s00_axi_awready = wr_hs;
    assign s00_axi_wready  = wr_hs;
    assign s00_axi_arready = rd_hs;

    assign waddr       = {s00_axi_awaddr[AW-1:2], 2'b00};
    assign raddr       = {s00_axi_araddr[AW-1:2], 2'b00};
    assign busy        = (state_q == BUSY);
    assign done_evt    = core_done && busy;
    assign start_req   = wr_hs && (waddr == A_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[0];
    assign wr_data_reg = wr_hs && (waddr >= A_ACC_XY) && (waddr <= A_GYR_Z);
    assign wr_reject   = busy && (start_req || wr_data_reg);
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign core_ax = acc_xy[15:0];
    assign core_ay = acc_xy[31:16];
    assign core_az = acc_z;
    assign core_gx = gyr_xy[15:0];
    assign core_gy = gyr_xy[31:16];
    assign core_gz = gyr_z;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: if (start_req) begin
                state_d = BUSY;
                start_d = 1'b1;
            end
            BUSY: if (core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MQFU_AXIL_REGS_IRQ_EN
    logic irq_en;
    assign irq_en_bit = irq_en;
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (raddr)
            A_CTRL:   rd_mux = {30'h0, irq_en_bit, 1'b0};
            A_STATUS: rd_mux = {30'h0, done, busy};
            A_ACC_XY: rd_mux = acc_xy;
            A_ACC_Z:  rd_mux = {16'h0, acc_z};
            A_GYR_XY: rd_mux = gyr_xy;
            A_GYR_Z:  rd_mux = {16'h0, gyr_z};
            A_Q0:     rd_mux = q0;
            A_Q1:     rd_mux = q1;
            A_Q2:     rd_mux = q2;
            A_Q3:     rd_mux = q3;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state_q <= IDLE;
            core_start <= 1'b0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp <= 2'b00;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rresp <= 2'b00;
            s00_axi_rdata <= '0;
            {acc_xy, gyr_xy, acc_z, gyr_z} <= '0;
            {q0, q1, q2, q3} <= '0;
            done <= 1'b0;
`ifdef MQFU_AXIL_REGS_IRQ_EN
            irq_en <= 1'b0;
            irq <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            core_start <= start_d;

            if (wr_hs) begin
                s00_axi_bvalid <= 1'b1;
                s00_axi_bresp <= wr_reject ? 2'b10 : 2'b00;
            end else if (s00_axi_bready) begin
                s00_axi_bvalid <= 1'b0;
            end

            if (wr_hs && !wr_reject) begin
                case (waddr)
`ifdef MQFU_AXIL_REGS_IRQ_EN
                    A_CTRL:   if (s00_axi_wstrb[0]) irq_en <= s00_axi_wdata[1];
`endif
                    A_ACC_XY: acc_xy <= merge(acc_xy, s00_axi_wdata, s00_axi_wstrb);
                    A_GYR_XY: gyr_xy <= merge(gyr_xy, s00_axi_wdata, s00_axi_wstrb);
                    A_ACC_Z: begin
                        if (s00_axi_wstrb[0]) acc_z[7:0]  <= s00_axi_wdata[7:0];
                        if (s00_axi_wstrb[1]) acc_z[15:8] <= s00_axi_wdata[15:8];
                    end
                    A_GYR_Z: begin
                        if (s00_axi_wstrb[0]) gyr_z[7:0]  <= s00_axi_wdata[7:0];
                        if (s00_axi_wstrb[1]) gyr_z[15:8] <= s00_axi_wdata[15:8];
                    end
                    default: ;
                endcase
            end

            // A completion in the same cycle as a W1C keeps DONE set.
            if (done_evt) begin
                done <= 1'b1;
                {q0, q1, q2, q3} <= {core_q0, core_q1, core_q2, core_q3};
            end else if (wr_hs && (waddr == A_STATUS) && s00_axi_wstrb[0] && s00_axi_wdata[1]) begin
                done <= 1'b0;
            end

            if (rd_hs) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata <= rd_mux;
                s00_axi_rresp <= 2'b00;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
`ifdef MQFU_AXIL_REGS_IRQ_EN
            irq <= done && irq_en;
`endif
        end
    end
endmodule

// File: tb/tb_mqfu_axil_regs.sv
// Scoreboard bench for mqfu_axil_regs: tasks queue expected B/R responses, a negedge monitor checks them.
// Interrupt checks run only when MQFU_AXIL_REGS_IRQ_EN is defined.
module tb_mqfu_axil_regs;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [5:0]  awaddr = 0, araddr = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;
    logic        arvalid = 0, arready, rvalid, rready = 0;
    logic        irq, core_start, core_done = 0;
    logic signed [15:0] core_ax, core_ay, core_az, core_gx, core_gy, core_gz;
    logic [31:0] core_q0 = 0, core_q1 = 0, core_q2 = 0, core_q3 = 0;

    mqfu_axil_regs dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
`ifdef MQFU_AXIL_REGS_IRQ_EN
        .irq(irq),
`endif
        .core_start(core_start),
        .core_ax(core_ax), .core_ay(core_ay), .core_az(core_az),
        .core_gx(core_gx), .core_gy(core_gy), .core_gz(core_gz),
        .core_done(core_done),
        .core_q0(core_q0), .core_q1(core_q1), .core_q2(core_q2), .core_q3(core_q3)
    );
`ifndef MQFU_AXIL_REGS_IRQ_EN
    assign irq = 1'b0;
`endif

    typedef struct { logic [5:0] a; logic [31:0] d; } rexp_t;
    logic [1:0] exp_b[$];
    rexp_t      exp_r[$];
    int checks = 0, errors = 0, start_cnt = 0;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
`ifdef MQFU_AXIL_REGS_IRQ_EN
    localparam logic [31:0] CTRL_IE = 32'h2;
`else
    localparam logic [31:0] CTRL_IE = 32'h0;
`endif

    always @(negedge clk) if (!rst && core_start) start_cnt++;

    // Response monitor
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++; $display("FAIL bresp_unexpected actual=%b", bresp);
            end else begin
                logic [1:0] e;
                e = exp_b.pop_front();
                if (bresp !== e) begin errors++; $display("FAIL bresp actual=%b expected=%b", bresp, e); end
            end
        end
        if (!rst && rvalid && rready) begin
            checks++;
            if (exp_r.size() == 0) begin
                errors++; $display("FAIL rdata_unexpected actual=%h", rdata);
            end else begin
                rexp_t e;
                e = exp_r.pop_front();
                if (rdata !== e.d || rresp !== OKAY)
                    begin errors++; $display("FAIL rdata@%h actual=%h/%b expected=%h/00", e.a, rdata, rresp, e.d); end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%h expected=%h", name, act, exp); end
    endtask

    task automatic timeout(input string name);
        checks++; errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] e, input bit with_done = 0);
        int n;
        exp_b.push_back(e);
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        if (with_done) core_done = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(awready && wready) && n < 20);
        if (!(awready && wready)) timeout("write_accept");
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; core_done = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 20);
        if (!bvalid) timeout("write_resp");
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] d);
        int n;
        rexp_t x;
        x.a = a; x.d = d;
        exp_r.push_back(x);
        @(posedge clk); #1;
        araddr = a; arvalid = 1; rready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) timeout("read_accept");
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        if (!rvalid) timeout("read_resp");
        @(posedge clk); #1;
    endtask

    task automatic pulse_done(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        @(posedge clk); #1;
        core_done = 1; core_q0 = a; core_q1 = b; core_q2 = c; core_q3 = d;
        @(posedge clk); #1;
        core_done = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_bvalid", {31'h0, bvalid}, 0);
        chk("reset_rvalid", {31'h0, rvalid}, 0);
        chk("reset_core_start", {31'h0, core_start}, 0);
        chk("reset_irq", {31'h0, irq}, 0);
        axi_read(6'h04, 32'h0);
        axi_read(6'h18, 32'h0);

        // operand registers, z upper half not stored
        axi_write(6'h08, 32'h0001_0002, 4'hF, OKAY);
        axi_write(6'h0C, 32'h0000_0003, 4'hF, OKAY);
        axi_write(6'h10, 32'h1234_ABCD, 4'hF, OKAY);
        axi_write(6'h14, 32'hABCD_FFF0, 4'hF, OKAY);
        axi_read(6'h08, 32'h0001_0002);
        axi_read(6'h0C, 32'h0000_0003);
        axi_read(6'h10, 32'h1234_ABCD);
        axi_read(6'h14, 32'h0000_FFF0);
        axi_write(6'h10, 32'h5566_7788, 4'b0101, OKAY);
        axi_read(6'h10, 32'h1266_AB88);

        axi_write(6'h28, 32'hFFFF_FFFF, 4'hF, OKAY);
        axi_read(6'h28, 32'h0);
        axi_read(6'h3C, 32'h0);
        axi_write(6'h00, 32'h2, 4'hF, OKAY);
        axi_read(6'h00, CTRL_IE);

        // start a run
        axi_write(6'h00, 32'h3, 4'hF, OKAY);
        chk("start_pulses", start_cnt, 1);
        axi_read(6'h04, 32'h1);
        axi_read(6'h00, CTRL_IE);
        chk("core_ax", {16'h0, core_ax}, 32'h0002);
        chk("core_ay", {16'h0, core_ay}, 32'h0001);
        chk("core_gx", {16'h0, core_gx}, 32'hAB88);
        chk("core_gz", {16'h0, core_gz}, 32'hFFF0);

        // busy rejects operand and start writes
        axi_write(6'h08, 32'hFFFF_FFFF, 4'hF, SLVERR);
        axi_write(6'h00, 32'h3, 4'hF, SLVERR);
        axi_write(6'h00, 32'h2, 4'hF, OKAY);
        chk("busy_no_restart", start_cnt, 1);
        axi_read(6'h08, 32'h0001_0002);
        chk("busy_core_ax_held", {16'h0, core_ax}, 32'h0002);

        pulse_done(32'h3F80_0000, 32'h1, 32'h2, 32'h3);
`ifdef MQFU_AXIL_REGS_IRQ_EN
        @(negedge clk); chk("irq_lag", {31'h0, irq}, 0);
        @(negedge clk); chk("irq_set", {31'h0, irq}, 1);
`endif
        axi_read(6'h04, 32'h2);
        axi_read(6'h18, 32'h3F80_0000);
        axi_read(6'h1C, 32'h1);
        axi_read(6'h20, 32'h2);
        axi_read(6'h24, 32'h3);
        axi_write(6'h04, 32'h2, 4'hF, OKAY);
        axi_read(6'h04, 32'h0);
        chk("irq_cleared", {31'h0, irq}, 0);

        // completion coincides with W1C: set wins
        axi_write(6'h00, 32'h3, 4'hF, OKAY);
        chk("start_pulses_2", start_cnt, 2);
        core_q0 = 32'h4000_0000;
        axi_write(6'h04, 32'h2, 4'hF, OKAY, 1);
        axi_read(6'h04, 32'h2);
        axi_read(6'h18, 32'h4000_0000);
        axi_write(6'h04, 32'h2, 4'hF, OKAY);
        axi_read(6'h04, 32'h0);

        // core_done in IDLE is ignored
        pulse_done(32'h1111_1111, 32'h0, 32'h0, 32'h0);
        axi_read(6'h04, 32'h0);
        axi_read(6'h18, 32'h4000_0000);

        // B channel back-pressure
        exp_b.push_back(OKAY);
        @(posedge clk); #1;
        awaddr = 6'h0C; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(negedge clk); chk("bp_first_accept", {31'h0, awready}, 1);
        @(posedge clk); #1;
        wdata = 32'h9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_bvalid", {31'h0, bvalid}, 1);
            chk("bp_awready", {31'h0, awready}, 0);
            chk("bp_wready", {31'h0, wready}, 0);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        @(posedge clk); #1;
        axi_read(6'h0C, 32'h7);

        // reset while busy
        axi_write(6'h00, 32'h1, 4'hF, OKAY);
        chk("start_pulses_3", start_cnt, 3);
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        axi_read(6'h04, 32'h0);
        pulse_done(32'hDEAD_BEEF, 32'h1, 32'h1, 32'h1);
        axi_read(6'h04, 32'h0);
        axi_read(6'h18, 32'h0);
        axi_read(6'h08, 32'h0);

        // same-cycle read and write: read sees old value
        fork
            axi_write(6'h0C, 32'h55, 4'hF, OKAY);
            axi_read(6'h0C, 32'h0);
        join
        axi_read(6'h0C, 32'h55);

        repeat (5) @(posedge clk);
        chk("b_queue_drained", exp_b.size(), 0);
        chk("r_queue_drained", exp_r.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mqfu_axil_regs.md
MQFU_AXIL_REGS -- requirements
Module: mqfu_axil_regs

Interface
REQ-001 The module SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 The module SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with these ports:
- s00_axi_aclk  in  1  sole clock; all logic on its rising edge.
- s00_axi_areset  in  1  synchronous, active-high reset.
REQ-004 The module SHALL have the AXI4-Lite slave ports s00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready, with standard AXI4-Lite widths and directions.
REQ-005 The module SHALL have the following core-side ports:
- core_start  out  1  one-cycle start pulse to the filter core.
- core_ax, core_ay, core_az, core_gx, core_gy, core_gz  out  16 each  signed sample operands, held stable while busy.
- core_done  in  1  one-cycle completion pulse from the core.
- core_q0..core_q3  in  32 each  quaternion result, valid in the core_done cycle.
REQ-006 The module SHALL have an irq output, 1 bit, level interrupt, present only when the macro in REQ-020 is defined.

Function
REQ-007 The register map SHALL be:
- 0x00 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (R/W).
- 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (W1C).
- 0x08 ACC_XY = {ay, ax}.
- 0x0C ACC_Z = {16'h0, az}.
- 0x10 GYR_XY = {gy, gx}.
- 0x14 GYR_Z = {16'h0, gz}.
- 0x18–0x24 Q0–Q3, read-only.
- Unmapped addresses read 0 and ignore writes, with OKAY response.
REQ-008 Write channel: awready and wready SHALL assert together for one cycle only when awvalid && wvalid && !bvalid; the register update occurs in that cycle.
REQ-009 bvalid SHALL assert the cycle after the write handshake and hold until bready; no new write is accepted while bvalid=1.
REQ-010 Read channel: arready SHALL pulse for one cycle when arvalid && !rvalid; rvalid and rdata SHALL follow one cycle later and hold stable until rready.
REQ-011 Writes to 0x08–0x14 SHALL honour wstrb byte lanes.
REQ-012 The FSM states SHALL be IDLE, BUSY:
- IDLE→BUSY when START is written 1; core_start pulses for exactly 1 cycle, on the cycle after the handshake.
- BUSY→IDLE on core_done.
REQ-013 In BUSY, writes to CTRL.START or to 0x08–0x14 SHALL be ignored and return bresp=SLVERR (2'b10); all other accesses return OKAY.
REQ-014 On core_done, core_q0..q3 SHALL be captured into Q0–Q3 and DONE SHALL set; Q0–Q3 hold until the next core_done.
REQ-015 If core_done and a DONE W1C write occur in the same cycle, DONE SHALL remain 1 (set wins).
REQ-016 A core_done received in IDLE SHALL be ignored: no capture, no DONE change.
REQ-017 Reads and writes SHALL proceed independently; a same-cycle read and write to one register returns the pre-write value.

Reset
REQ-018 While s00_axi_areset=1 at a clock edge, the module SHALL:
- force the FSM to IDLE;
- clear all registers, Q0–Q3, DONE and IRQ_EN;
- drive awready, wready, arready, bvalid, rvalid, core_start and irq to 0, and bresp, rresp, rdata to 0.
REQ-019 Reset asserted mid-transaction or while BUSY SHALL abandon the outstanding response and state; a later core_done is then ignored per REQ-016.

Configuration
REQ-020 Macro MQFU_AXIL_REGS_IRQ_EN controls the interrupt:
- Defined: irq is a registered output equal to DONE && IRQ_EN.
- Undefined: the irq port is absent, CTRL bit1 reads 0, and writes to it have no effect.

Verification
REQ-021 Write 0x00010002 to 0x08, 0x00000003 to 0x0C, and sample data to 0x10/0x14, then read back -> ACC_XY=0x00010002, ACC_Z=0x00000003, all bresp=OKAY.
REQ-022 Write CTRL=0x1 -> exactly one core_start pulse and STATUS=0x1; core_ax=0x0002; core_done with core_q0=0x3F800000 -> STATUS=0x2, Q0 reads 0x3F800000.
REQ-023 While BUSY, write 0x08=0xFFFFFFFF -> bresp=SLVERR, and ACC_XY is unchanged on readback.
REQ-024 Assert core_done in the same cycle as a W1C write of 0x2 to STATUS -> DONE reads 1; a second W1C write -> DONE reads 0.
REQ-025 Hold bready=0 for 10 cycles after a write -> bvalid stays 1 and awready/wready stay 0 despite a pending awvalid/wvalid.
REQ-026 With the macro defined, IRQ_EN=1 and a completed run -> irq=1 one cycle after DONE sets; W1C DONE -> irq=0. Assert reset while BUSY -> STATUS=0 and no capture on a subsequent core_done.
